ik_swift_hps_master_0_p2b_converter: RTL and testbench

//  Avalon-ST packets-to-bytes converter. Sits directly downstream of the p2b channel adapter
//  in the HPS master bridge. Serialises each packet beat (data, channel, SOP, EOP) into a

---
 rtl/ik_swift_hps_master_0_p2b_converter.sv | 155 +++++++++++++++
 tb/tb_ik_swift_hps_master_0_p2b_converter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ik_swift_hps_master_0_p2b_converter.sv
// Avalon-ST packets-to-bytes encoder: serialises channel/SOP/EOP/data of each beat
// into one escaped byte stream with a combinational data path and a token-sequencing FSM.
//
// state       | meaning (next token to emit)
// ST_BEGIN    | first applicable token of the beat (CHAN mark, SOP, EOP or data)
// ST_CHAN_VAL | channel byte, or ESC if the channel byte is reserved
// ST_CHAN_ESC | escaped channel byte (channel ^ 0x20)
// ST_SOP      | SOP marker
// ST_EOP      | EOP marker
// ST_DATA     | data byte, or ESC if the data byte is reserved
// ST_DATA_ESC | escaped data byte (data ^ 0x20)
module ik_swift_hps_master_0_p2b_converter #(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic [CHANNEL_WIDTH-1:0] in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data
);

  localparam logic [7:0] SOP_CHAR  = 8'h7A;
  localparam logic [7:0] EOP_CHAR  = 8'h7B;
  localparam logic [7:0] CHAN_CHAR = 8'h7C;
  localparam logic [7:0] ESC_CHAR  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  typedef enum logic [2:0] {
    ST_BEGIN,
    ST_CHAN_VAL,
    ST_CHAN_ESC,
    ST_SOP,
    ST_EOP,
    ST_DATA,
    ST_DATA_ESC
  } state_t;

  state_t     state_q, state_d;
  logic       chan_known_q, chan_known_d;
  logic [7:0] last_channel_q, last_channel_d;

  logic [7:0] chan8;
  logic       need_chan;
  logic       chan_rsvd;
  logic       data_rsvd;
  state_t     after_chan;
  state_t     after_sop;
  state_t     tok_next;
  logic [7:0] tok_data;
  logic       final_tok;
  logic       advance;

  always_comb begin
    chan8      = 8'(in_channel);
    need_chan  = in_startofpacket || !chan_known_q || (chan8 != last_channel_q);
    chan_rsvd  = (chan8 >= SOP_CHAR) && (chan8 <= ESC_CHAR);
    data_rsvd  = (in_data >= SOP_CHAR) && (in_data <= ESC_CHAR);
    after_chan = in_startofpacket ? ST_SOP : (in_endofpacket ? ST_EOP : ST_DATA);
    after_sop  = in_endofpacket ? ST_EOP : ST_DATA;

    tok_data  = 8'h00;
    tok_next  = state_q;
    final_tok = 1'b0;

    case (state_q)
      ST_BEGIN: begin
        // Skip straight to the first token this beat actually needs.
        if (need_chan) begin
          tok_data = CHAN_CHAR;
          tok_next = ST_CHAN_VAL;
        end else if (in_startofpacket) begin
          tok_data = SOP_CHAR;
          tok_next = after_sop;
        end else if (in_endofpacket) begin
          tok_data = EOP_CHAR;
          tok_next = ST_DATA;
        end else if (data_rsvd) begin
          tok_data = ESC_CHAR;
          tok_next = ST_DATA_ESC;
        end else begin
          tok_data  = in_data;
          tok_next  = ST_BEGIN;
          final_tok = 1'b1;
        end
      end
      ST_CHAN_VAL: begin
        if (chan_rsvd) begin
          tok_data = ESC_CHAR;
          tok_next = ST_CHAN_ESC;
        end else begin
          tok_data = chan8;
          tok_next = after_chan;
        end
      end
      ST_CHAN_ESC: begin
        tok_data = chan8 ^ ESC_XOR;
        tok_next = after_chan;
      end
      ST_SOP: begin
        tok_data = SOP_CHAR;
        tok_next = after_sop;
      end
      ST_EOP: begin
        tok_data = EOP_CHAR;
        tok_next = ST_DATA;
      end
      ST_DATA: begin
        if (data_rsvd) begin
          tok_data = ESC_CHAR;
          tok_next = ST_DATA_ESC;
        end else begin
          tok_data  = in_data;
          tok_next  = ST_BEGIN;
          final_tok = 1'b1;
        end
      end
      ST_DATA_ESC: begin
        tok_data  = in_data ^ ESC_XOR;
        tok_next  = ST_BEGIN;
        final_tok = 1'b1;
      end
      default: begin
        tok_next = ST_BEGIN;
      end
    endcase

    advance   = in_valid && out_ready && !reset;
    out_valid = in_valid && !reset;
    out_data  = tok_data;
    in_ready  = advance && final_tok;

    state_d        = advance ? tok_next : state_q;
    chan_known_d   = chan_known_q || in_ready;
    last_channel_d = in_ready ? chan8 : last_channel_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_BEGIN;
      chan_known_q   <= 1'b0;
      last_channel_q <= 8'h00;
    end else begin
      state_q        <= state_d;
      chan_known_q   <= chan_known_d;
      last_channel_q <= last_channel_d;
    end
  end

endmodule

// File: tb/tb_ik_swift_hps_master_0_p2b_converter.sv
// Scoreboard bench for the packets-to-bytes encoder: a beat-level encoding model fills an
// expected-token queue; a negedge monitor checks every presented byte and in_ready against it.
module tb_ik_swift_hps_master_0_p2b_converter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] in_channel;
  logic       in_startofpacket;
  logic       in_endofpacket;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;

  ik_swift_hps_master_0_p2b_converter #(.CHANNEL_WIDTH(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_ready         (in_ready),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_channel       (in_channel),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } tok_t;

  tok_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pop_cnt  = 0;
  int   ready_mode = 0;   // 0: always ready, 1: toggle each cycle, 2: random
  bit   gaps_en  = 0;
  bit   m_known  = 0;
  logic [7:0] m_last = 8'h00;

  // Reference model: the byte sequence a beat must produce, with in_ready on its last byte.
  function automatic void push_byte(input logic [7:0] b, input bit last);
    tok_t t;
    if (b >= 8'h7A && b <= 8'h7D) begin
      t.b = 8'h7D; t.last = 0; exp_q.push_back(t);
      t.b = b ^ 8'h20; t.last = last; exp_q.push_back(t);
    end else begin
      t.b = b; t.last = last; exp_q.push_back(t);
    end
  endfunction

  function automatic void model_beat(input bit sop, input bit eop,
                                     input logic [7:0] ch, input logic [7:0] d);
    tok_t t;
    if (sop || !m_known || ch != m_last) begin
      t.b = 8'h7C; t.last = 0; exp_q.push_back(t);
      push_byte(ch, 0);
    end
    if (sop) begin t.b = 8'h7A; t.last = 0; exp_q.push_back(t); end
    if (eop) begin t.b = 8'h7B; t.last = 0; exp_q.push_back(t); end
    push_byte(d, 1);
    m_known = 1;
    m_last  = ch;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_gate: out_valid=%b in_ready=%b, required 0/0", out_valid, in_ready);
      end
    end else if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_byte: out_data=%02h with empty expectation queue", out_data);
      end else begin
        n_checks++;
        if (out_data !== exp_q[0].b) begin
          n_fail++;
          $display("FAIL out_data: got %02h, required %02h (t=%0t)", out_data, exp_q[0].b, $time);
        end
        n_checks++;
        if (in_ready !== (out_ready && exp_q[0].last)) begin
          n_fail++;
          $display("FAIL in_ready: got %b, required %b (t=%0t)", in_ready,
                   out_ready && exp_q[0].last, $time);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          pop_cnt++;
        end
      end
    end else begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL in_ready_idle: got %b while out_valid=0, required 0", in_ready);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  task automatic drive(input bit sop, input bit eop, input logic [7:0] ch, input logic [7:0] d);
    in_startofpacket = sop;
    in_endofpacket   = eop;
    in_channel       = ch;
    in_data          = d;
    in_valid         = 1'b1;
    model_beat(sop, eop, ch, d);
  endtask

  // Issue a beat at posedge+1 and hold it until the DUT consumes it.
  task automatic send_beat(input bit sop, input bit eop, input logic [7:0] ch, input logic [7:0] d);
    int budget;
    drive(sop, eop, ch, d);
    budget = 200;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      budget--;
      if (budget == 0) begin
        n_checks++; n_fail++;
        $display("FAIL beat_timeout: in_ready=0 after 200 cycles, required 1");
        exp_q.delete();
        break;
      end
      @(posedge clk); #1;
      if (gaps_en) in_valid = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    m_known = 0;
    m_last  = 8'h00;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected bytes never emitted, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    int start;
    int budget;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_channel = 8'h00;
    in_startofpacket = 1'b0; in_endofpacket = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Directed cases
    send_beat(1, 0, 8'h00, 8'h41);   // 7C 00 7A 41
    send_beat(0, 1, 8'h00, 8'h7B);   // 7B 7D 5B
    send_beat(1, 1, 8'h7D, 8'h10);   // 7C 7D 5D 7A 7B 10
    check_drained("directed_basic");

    do_reset();
    ready_mode = 1;
    send_beat(1, 0, 8'h00, 8'h41);   // same bytes under toggling backpressure
    ready_mode = 0;
    send_beat(0, 0, 8'h01, 8'h05);   // 7C 01 05
    send_beat(0, 0, 8'h01, 8'h05);   // 05
    send_beat(0, 0, 8'h02, 8'h06);   // 7C 02 06
    check_drained("directed_midpkt");

    // Abandon a beat right after its CHAN mark, then resend without SOP.
    @(posedge clk); #1;
    start = pop_cnt;
    drive(1, 0, 8'h00, 8'h41);
    budget = 50;
    while (pop_cnt < start + 1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_checks++; n_fail++;
      $display("FAIL abort_timeout: first byte never accepted, required 1 byte");
    end
    do_reset();
    send_beat(0, 0, 8'h00, 8'h41);   // 7C 00 41
    check_drained("directed_reset");

    // Randomised traffic with reserved-heavy values, backpressure and valid gaps.
    ready_mode = 2;
    gaps_en    = 1;
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ch, d;
      ch = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'h7A, 8'h7D)) : 8'($urandom_range(0, 3));
      d  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8'h7A, 8'h7D)) : 8'($urandom);
      if ($urandom_range(0, 60) == 0) do_reset();
      send_beat($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, ch, d);
    end
    check_drained("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
